maprom_reset_timer: RTL and testbench
=====================================

# maprom_reset_timer

Measures how long the Amiga keyboard/system reset line is held and issues the maprom control pulses that the RAM/maprom decoder consumes: `rst_maprom_off` (held ≥ 3 s, maprom disabled) and `rst_maprom_rst` (held ≥ 6 s, maprom disabled and capture counter cleared). It sits between the raw `_RST` pin and the maprom decoder. It synchronises and debounces the line, prescales the clock into coarse ticks, and runs a small FSM that fires the pulses on reset release.

## Interface
Parameters:
- `TICK_CYCLES`, 709379: CLK cycles per tick (100 ms at 7.09379 MHz).
- `OFF_TICKS`, 30: tick count for the disable level (3 s).
- `RST_TICKS`, 60: tick count for the full-clear level (6 s). Must be > `OFF_TICKS`.
- `DEBOUNCE`, 16: consecutive stable synchronised samples required before accepting a level change.
- `PULSE_CYCLES`, 4: output pulse width in CLK cycles.

Ports:
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `_RST`  in  1  Amiga reset line, asynchronous, active-low.
- `rst_maprom_off`  out  1  high pulse: disable maprom.
- `rst_maprom_rst`  out  1  high pulse: clear maprom capture state.
- `hold_level`  out  2  0 = below 3 s, 1 = ≥ 3 s, 2 = ≥ 6 s; valid only in HELD, otherwise 0.
- `led`  out  1  present only with `MAPROM_HOLD_LED_EN`.

## Operation
- Input path: 2-FF synchroniser, then debounce counter. The debounced level `rst_n_db` changes only after `DEBOUNCE` consecutive samples differ from it. The counter restarts on any sample equal to `rst_n_db`.
- Tick prescaler: counts 0..`TICK_CYCLES`-1 and emits a 1-cycle tick on wrap. It is zeroed when HELD is entered.
- Hold counter `ticks`: counts ticks in HELD and saturates at `RST_TICKS`. Width is clog2(`RST_TICKS`+1).
- FSM states:
  - WAIT_HIGH: after `RST`. Moves to IDLE once `rst_n_db`=1. A reset held across power-up never counts.
  - IDLE: moves to HELD when `rst_n_db` falls; clears `ticks`.
  - HELD: counts ticks. On `rst_n_db` rise:
    - `ticks` ≥ `RST_TICKS`: load PULSE with both outputs set.
    - `ticks` ≥ `OFF_TICKS`: load PULSE with `rst_maprom_off` only.
    - otherwise: go to IDLE with no pulse.
  - PULSE: holds the selected outputs for exactly `PULSE_CYCLES` cycles, then goes to IDLE. Input changes are ignored. If `rst_n_db` is still low on return to IDLE, a new hold starts the next cycle.
- Threshold compare uses `ticks` as registered on the release cycle. A tick coincident with release is not counted.
- `hold_level` is registered and derived from `ticks` while in HELD.

## Timing
- Reset values: all outputs 0, state WAIT_HIGH, `ticks`=0, prescaler 0, `rst_n_db`=1, debounce counter 0.
- `RST` mid-operation (HELD or PULSE): outputs are 0 on the next cycle, any pulse in progress is aborted, and the FSM returns to WAIT_HIGH.
- Input latency: 2 sync cycles + `DEBOUNCE` cycles from a pin edge to the `rst_n_db` change.
- Pulse timing: outputs rise 1 cycle after `rst_n_db` rises and stay high exactly `PULSE_CYCLES` cycles. Both outputs are glitch-free registers, as the maprom decoder uses them as async clear/set.
- Hold time resolution is ±1 tick plus the debounce delay.

## Configuration
- `MAPROM_HOLD_LED_EN` defined: adds `led`.
  - IDLE/WAIT_HIGH: 0.
  - HELD with level 0: 1.
  - Level 1: toggles every 4 ticks.
  - Level 2: toggles every tick.
  - PULSE: 0.
- Undefined: the `led` port and blink logic are absent; all other behaviour is identical.

## Structure
- Shared package `maprom_pkg` holds:
  - FSM state enum (WAIT_HIGH, IDLE, HELD, PULSE).
  - `hold_level` encodings (LVL_NONE=0, LVL_OFF=1, LVL_RST=2).
  - Default timing constants.
- One sub-module, `sync_debounce`: synchroniser plus debounce counter, parameterised by `DEBOUNCE`, reset value 1.

## Test plan
All scenarios use `TICK_CYCLES`=10, `OFF_TICKS`=3, `RST_TICKS`=6, `DEBOUNCE`=4, `PULSE_CYCLES`=4.
- `_RST` low for 25 cycles (2 ticks) then high -> no pulses; `hold_level` peaks at 0; FSM returns to IDLE.
- `_RST` low for 45 cycles -> `rst_maprom_off` high for exactly 4 cycles after release; `rst_maprom_rst` stays 0; `hold_level` reaches 1.
- `_RST` low for 80 cycles -> both outputs high for exactly the same 4 cycles; `hold_level` reaches 2; `ticks` saturates at 6.
- 3-cycle low glitch on `_RST` -> `rst_n_db` never changes; no state change.
- `RST` asserted at tick 5 of a hold -> outputs 0 next cycle, state WAIT_HIGH; releasing `_RST` afterwards gives no pulse.
- `_RST` low during `RST` release and held 100 cycles, then high -> no pulse (WAIT_HIGH→IDLE only). A subsequent 45-cycle hold -> `rst_maprom_off` pulse.

Source files
------------

// File: rtl/maprom_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// maprom_pkg
// Shared FSM states, hold-level encodings and default timing constants for
// the maprom reset timer.
// Revision: 1.0
// ============================================================================
package maprom_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_HIGH = 2'd0,
      ST_IDLE      = 2'd1,
      ST_HELD      = 2'd2,
      ST_PULSE     = 2'd3
   } state_t;

   localparam logic [1:0] LVL_NONE = 2'd0;
   localparam logic [1:0] LVL_OFF  = 2'd1;
   localparam logic [1:0] LVL_RST  = 2'd2;

   localparam int DEF_TICK_CYCLES  = 709379;
   localparam int DEF_OFF_TICKS    = 30;
   localparam int DEF_RST_TICKS    = 60;
   localparam int DEF_DEBOUNCE     = 16;
   localparam int DEF_PULSE_CYCLES = 4;

endpackage
`default_nettype wire

// File: rtl/sync_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sync_debounce
// Two-flop synchroniser plus debounce counter for an active-low line; the
// level and synchroniser reset to 1. o_valid marks the end of the post-reset
// settling window.
// Revision: 1.0
// ============================================================================
module sync_debounce #(
   parameter int DEBOUNCE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async_n,
   output logic o_level,
   output logic o_valid
);

   localparam int              c_cw        = $clog2(DEBOUNCE + 4);
   localparam logic [c_cw-1:0] c_db_last   = c_cw'(DEBOUNCE - 1);
   localparam logic [c_cw-1:0] c_warm_done = c_cw'(DEBOUNCE + 3);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_level;
   logic [c_cw-1:0] r_cnt;
   logic [c_cw-1:0] r_warm;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_level <= 1'b1;
         r_cnt   <= '0;
         r_warm  <= '0;
      end else begin
         r_sync1 <= i_async_n;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_db_last) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         // Settling window: the reset value of r_level says nothing about the pin.
         if (r_warm != c_warm_done) begin
            r_warm <= r_warm + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_valid = (r_warm == c_warm_done);

endmodule
`default_nettype wire

// File: rtl/maprom_reset_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// maprom_reset_timer
// Times how long the Amiga reset line is held and pulses the maprom disable /
// clear outputs on release. Optional blink LED: MAPROM_HOLD_LED_EN.
// Revision: 1.0
// ============================================================================
module maprom_reset_timer
   import maprom_pkg::*;
#(
   parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
   parameter int OFF_TICKS    = DEF_OFF_TICKS,
   parameter int RST_TICKS    = DEF_RST_TICKS,
   parameter int DEBOUNCE     = DEF_DEBOUNCE,
   parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       _RST,
   output logic       rst_maprom_off,
   output logic       rst_maprom_rst,
   output logic [1:0] hold_level
`ifdef MAPROM_HOLD_LED_EN
   ,
   output logic       led
`endif
);

   localparam int              c_pw         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int              c_tw         = $clog2(RST_TICKS + 1);
   localparam int              c_qw         = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [c_pw-1:0] c_presc_last = c_pw'(TICK_CYCLES - 1);
   localparam logic [c_tw-1:0] c_off_ticks  = c_tw'(OFF_TICKS);
   localparam logic [c_tw-1:0] c_rst_ticks  = c_tw'(RST_TICKS);
   localparam logic [c_qw-1:0] c_pulse_last = c_qw'(PULSE_CYCLES - 1);

   logic            w_rst_n_db;
   logic            w_db_valid;
   logic            w_tick;
   logic            w_enter_held;
   state_t          r_state;
   state_t          w_state_nxt;
   logic [c_pw-1:0] r_presc;
   logic [c_tw-1:0] r_ticks;
   logic [c_tw-1:0] w_ticks_nxt;
   logic [c_qw-1:0] r_pulse_cnt;
   logic            r_sel_rst;
   logic            w_off_nxt;
   logic            w_rst_nxt;
   logic [1:0]      w_lvl_nxt;
   logic            r_off;
   logic            r_rst;
   logic [1:0]      r_lvl;

   sync_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_sync_debounce (
      .clk       (CLK),
      .rst       (RST),
      .i_async_n (_RST),
      .o_level   (w_rst_n_db),
      .o_valid   (w_db_valid)
   );

   assign w_tick       = (r_presc == c_presc_last);
   assign w_enter_held = (r_state == ST_IDLE) && (w_state_nxt == ST_HELD);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_WAIT_HIGH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         // A line already low at reset must go high before any hold counts.
         ST_WAIT_HIGH: if (w_db_valid && w_rst_n_db) w_state_nxt = ST_IDLE;
         ST_IDLE:      if (!w_rst_n_db) w_state_nxt = ST_HELD;
         ST_HELD:      if (w_rst_n_db) w_state_nxt = (r_ticks >= c_off_ticks) ? ST_PULSE : ST_IDLE;
         ST_PULSE:     if (r_pulse_cnt == c_pulse_last) w_state_nxt = ST_IDLE;
         default:      w_state_nxt = ST_WAIT_HIGH;
      endcase
   end

   // A tick landing on the release cycle is not counted.
   always_comb begin
      w_ticks_nxt = r_ticks;
      if (r_state != ST_HELD) begin
         w_ticks_nxt = '0;
      end else if ((w_state_nxt == ST_HELD) && w_tick && (r_ticks < c_rst_ticks)) begin
         w_ticks_nxt = r_ticks + 1'b1;
      end
   end

   always_comb begin
      w_off_nxt = (w_state_nxt == ST_PULSE);
      w_rst_nxt = 1'b0;
      w_lvl_nxt = LVL_NONE;
      if (w_state_nxt == ST_PULSE) begin
         w_rst_nxt = (r_state == ST_HELD) ? (r_ticks >= c_rst_ticks) : r_sel_rst;
      end
      if (w_state_nxt == ST_HELD) begin
         if (w_ticks_nxt >= c_rst_ticks) begin
            w_lvl_nxt = LVL_RST;
         end else if (w_ticks_nxt >= c_off_ticks) begin
            w_lvl_nxt = LVL_OFF;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_presc     <= '0;
         r_ticks     <= '0;
         r_pulse_cnt <= '0;
         r_sel_rst   <= 1'b0;
         r_off       <= 1'b0;
         r_rst       <= 1'b0;
         r_lvl       <= LVL_NONE;
      end else begin
         if (w_enter_held || w_tick) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
         r_ticks <= w_ticks_nxt;
         if (r_state == ST_PULSE) begin
            r_pulse_cnt <= r_pulse_cnt + 1'b1;
         end else begin
            r_pulse_cnt <= '0;
         end
         if (r_state == ST_HELD) begin
            r_sel_rst <= (r_ticks >= c_rst_ticks);
         end
         r_off <= w_off_nxt;
         r_rst <= w_rst_nxt;
         r_lvl <= w_lvl_nxt;
      end
   end

   assign rst_maprom_off = r_off;
   assign rst_maprom_rst = r_rst;
   assign hold_level     = r_lvl;

`ifdef MAPROM_HOLD_LED_EN
   logic       r_led;
   logic [1:0] r_blink;

   always_ff @(posedge CLK) begin
      if (RST || (w_state_nxt != ST_HELD)) begin
         r_led   <= 1'b0;
         r_blink <= '0;
      end else if (w_lvl_nxt == LVL_NONE) begin
         r_led <= 1'b1;
      end else if (w_tick) begin
         if (w_lvl_nxt == LVL_RST) begin
            r_led <= ~r_led;
         end else begin
            r_blink <= r_blink + 1'b1;
            if (r_blink == 2'd3) begin
               r_led <= ~r_led;
            end
         end
      end
   end

   assign led = r_led;
`endif

endmodule
`default_nettype wire

// File: tb/tb_maprom_reset_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_maprom_reset_timer
// Self-checking bench: directed and random reset-line holds against a
// hold-length model of the expected pulses and hold level.
// Revision: 1.0
// ============================================================================
module tb_maprom_reset_timer;

   localparam int T    = 10;
   localparam int OFFT = 3;
   localparam int RSTT = 6;
   localparam int DB   = 4;
   localparam int PC   = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       pin = 1'b1;
   logic       off_o;
   logic       rst_o;
   logic [1:0] lvl_o;
`ifdef MAPROM_HOLD_LED_EN
   logic       led_o;
`endif

   int         n_checks = 0;
   int         n_pass   = 0;
   int         k_rel    = 0;
   int         n_off, n_rst, n_both, first_k, peak;

   maprom_reset_timer #(
      .TICK_CYCLES  (T),
      .OFF_TICKS    (OFFT),
      .RST_TICKS    (RSTT),
      .DEBOUNCE     (DB),
      .PULSE_CYCLES (PC)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      ._RST           (pin),
      .rst_maprom_off (off_o),
      .rst_maprom_rst (rst_o),
      .hold_level     (lvl_o)
`ifdef MAPROM_HOLD_LED_EN
      ,
      .led            (led_o)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic clear_acc();
      n_off = 0; n_rst = 0; n_both = 0; first_k = -1; peak = 0;
   endtask

   // One cycle: sample outputs at the falling edge, then drive the pin.
   task automatic step(input logic lvl);
      @(negedge CLK);
      k_rel++;
      if (off_o) n_off++;
      if (rst_o) n_rst++;
      if (off_o && rst_o) n_both++;
      if (int'(lvl_o) > peak) peak = int'(lvl_o);
      if (off_o && first_k < 0) first_k = k_rel;
      if (lvl && !pin) k_rel = 0;
      pin = lvl;
   endtask

   // Reference: a low of L cycles (L >= DB) keeps the FSM in HELD for L cycles
   // and accumulates floor((L-1)/T) ticks, saturating at RSTT.
   task automatic hold(input int L, input int gap, input string tag);
      bit held;
      int n, e_off, e_rst, e_lvl;
      clear_acc();
      for (int i = 0; i < L; i++) step(1'b0);
      for (int i = 0; i < gap; i++) step(1'b1);
      held  = (L >= DB);
      n     = held ? (((L - 1) / T) < RSTT ? (L - 1) / T : RSTT) : 0;
      e_off = (held && n >= OFFT) ? PC : 0;
      e_rst = (held && n >= RSTT) ? PC : 0;
      e_lvl = !held ? 0 : (n >= RSTT) ? 2 : (n >= OFFT) ? 1 : 0;
      chk($sformatf("%s L=%0d off_cycles", tag, L), n_off, e_off);
      chk($sformatf("%s L=%0d rst_cycles", tag, L), n_rst, e_rst);
      chk($sformatf("%s L=%0d both_cycles", tag, L), n_both, e_rst);
      chk($sformatf("%s L=%0d peak_level", tag, L), peak, e_lvl);
      if (e_off != 0) chk($sformatf("%s L=%0d rise_delay", tag, L), first_k, DB + 3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dir_l[8] = '{25, 45, 80, 3, 30, 31, 60, 61};

      // Reset state
      repeat (3) @(negedge CLK);
      chk("reset off", off_o, 0);
      chk("reset rst", rst_o, 0);
      chk("reset level", lvl_o, 0);
      RST = 1'b0;
      for (int i = 0; i < 15; i++) step(1'b1);

      foreach (dir_l[i]) hold(dir_l[i], 25, "dir");

      for (int i = 0; i < 12; i++)
         hold(int'($urandom_range(1, 85)), int'($urandom_range(20, 30)), "rnd");

      // RST asserted five ticks into a hold
      clear_acc();
      for (int i = 0; i < 62; i++) step(1'b0);
      chk("mid level_before_rst", lvl_o, 1);
      RST = 1'b1;
      @(negedge CLK);
      chk("mid off_after_rst", off_o, 0);
      chk("mid rst_after_rst", rst_o, 0);
      chk("mid level_after_rst", lvl_o, 0);
      RST = 1'b0;
      clear_acc();
      for (int i = 0; i < 30; i++) step(1'b0);
      for (int i = 0; i < 30; i++) step(1'b1);
      chk("mid off_no_pulse", n_off, 0);
      chk("mid rst_no_pulse", n_rst, 0);

      // Line held low across reset release never counts
      @(negedge CLK);
      pin = 1'b0;
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      clear_acc();
      for (int i = 0; i < 100; i++) step(1'b0);
      for (int i = 0; i < 30; i++) step(1'b1);
      chk("por off_no_pulse", n_off, 0);
      chk("por rst_no_pulse", n_rst, 0);
      chk("por peak_level", peak, 0);
      hold(45, 30, "after_por");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
